rgb_to_grayscale_stream: RTL and testbench

Pipelined, parametrised RGB-to-luma converter with valid/ready streaming handshake and per-beat selectable weighting mode.
- Successor to the combinational converter; sits between the pixel source (camera/DMA unpacker) and grayscale consumers (edge/threshold stages).
- Adds pixel-width generalisation, four weight sets, backpressure with bubble collapse, and `last` sideband pass-through.

---
 rtl/rgb_to_grayscale_pkg.sv | 32 +++
 rtl/rgb_to_grayscale_stream_pipe_stage.sv | 30 +++
 rtl/rgb_to_grayscale_stream.sv | 82 ++++++++
 tb/tb_rgb_to_grayscale_stream.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_grayscale_pkg.sv
// Shared types and coefficient tables for the streaming RGB-to-luma converter.
// Every weight set sums to 128 so the result never needs saturation.
package rgb_to_grayscale_pkg;

    typedef enum logic [1:0] {
        MODE_BT709 = 2'd0,
        MODE_BT601 = 2'd1,
        MODE_AVG   = 2'd2,
        MODE_GREEN = 2'd3
    } gray_mode_e;

    localparam int COEF_FRAC_W = 7;
    localparam int ROUND_BIAS  = 64;

    typedef struct packed {
        logic [7:0] cr;
        logic [7:0] cg;
        logic [7:0] cb;
    } coef_t;

    function automatic coef_t get_coef(gray_mode_e mode);
        coef_t coef;
        case (mode)
            MODE_BT709: coef = '{cr: 8'd27, cg: 8'd92,  cb: 8'd9};
            MODE_BT601: coef = '{cr: 8'd38, cg: 8'd75,  cb: 8'd15};
            MODE_AVG:   coef = '{cr: 8'd43, cg: 8'd42,  cb: 8'd43};
            default:    coef = '{cr: 8'd0,  cg: 8'd128, cb: 8'd0};
        endcase
        return coef;
    endfunction

endpackage

// File: rtl/rgb_to_grayscale_stream_pipe_stage.sv
// Generic valid/ready payload register; an empty or draining slot accepts new data,
// which lets a bubble upstream collapse while the downstream stage empties.
module grayscale_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/rgb_to_grayscale_stream.sv
// Two-stage streaming RGB-to-grayscale converter: S1 holds the weighted channel
// products, S2 holds the rounded luma; last travels alongside each beat.
module rgb_to_grayscale_stream
    import rgb_to_grayscale_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int FRAC_W  = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PIXEL_W-1:0] r_i,
    input  logic [PIXEL_W-1:0] g_i,
    input  logic [PIXEL_W-1:0] b_i,
    input  logic [1:0]         mode_i,
    input  logic               last_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [PIXEL_W-1:0] grayscale_o,
    output logic               last_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int PROD_W = PIXEL_W + 8;
    localparam int SUM_W  = PIXEL_W + 9;
    localparam int S1_W   = 3 * PROD_W + 1;
    localparam int S2_W   = PIXEL_W + 1;

    coef_t              coef;
    logic [PROD_W-1:0]  prod_r;
    logic [PROD_W-1:0]  prod_g;
    logic [PROD_W-1:0]  prod_b;
    logic [S1_W-1:0]    s1_in;
    logic [S1_W-1:0]    s1_out;
    logic               s1_valid;
    logic               s2_ready;
    logic [PROD_W-1:0]  s1_r;
    logic [PROD_W-1:0]  s1_g;
    logic [PROD_W-1:0]  s1_b;
    logic               s1_last;
    logic [SUM_W-1:0]   sum;
    logic [S2_W-1:0]    s2_in;
    logic [S2_W-1:0]    s2_out;

    // Coefficients follow the mode presented with the beat, so switching is per beat.
    assign coef   = get_coef(gray_mode_e'(mode_i));
    assign prod_r = PROD_W'(r_i) * PROD_W'(coef.cr);
    assign prod_g = PROD_W'(g_i) * PROD_W'(coef.cg);
    assign prod_b = PROD_W'(b_i) * PROD_W'(coef.cb);
    assign s1_in  = {last_i, prod_r, prod_g, prod_b};

    grayscale_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
        .clk      (clk_i),
        .rst      (rst_i),
        .up_valid (valid_i),
        .up_ready (ready_o),
        .up_data  (s1_in),
        .dn_valid (s1_valid),
        .dn_ready (s2_ready),
        .dn_data  (s1_out)
    );

    assign {s1_last, s1_r, s1_g, s1_b} = s1_out;

    // Round half up; the weights sum to 128, so the shifted sum always fits PIXEL_W.
    assign sum   = SUM_W'(s1_r) + SUM_W'(s1_g) + SUM_W'(s1_b) + SUM_W'(ROUND_BIAS);
    assign s2_in = {s1_last, PIXEL_W'(sum >> FRAC_W)};

    grayscale_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
        .clk      (clk_i),
        .rst      (rst_i),
        .up_valid (s1_valid),
        .up_ready (s2_ready),
        .up_data  (s2_in),
        .dn_valid (valid_o),
        .dn_ready (ready_i),
        .dn_data  (s2_out)
    );

    assign {last_o, grayscale_o} = s2_out;

endmodule

// File: tb/tb_rgb_to_grayscale_stream.sv
// Self-checking bench: vector table, handshake corner sequences and random streams
// against a scoreboard fed from an independent round-half-up luma model.
module tb_rgb_to_grayscale_stream;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] mode;
        logic       last;
        int         expected;
    } vec_t;

    typedef struct {
        int   gray;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] r, g, b, gray;
    logic [1:0] mode;
    logic       last, src_valid, dut_ready, gray_last, dut_valid, sink_ready;

    logic [9:0] r10, g10, b10, gray10;
    logic [1:0] mode10;
    logic       last10, valid10, dut10_ready, gray10_last, dut10_valid, sink10_ready;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t sb10[$];
    vec_t vecs[10];
    logic acc;
    logic [7:0] rr, gg, bb;
    logic [1:0] mm;
    logic ll;
    int guard;

    rgb_to_grayscale_stream #(.PIXEL_W(8), .FRAC_W(7)) dut (
        .clk_i(clk), .rst_i(rst), .r_i(r), .g_i(g), .b_i(b), .mode_i(mode),
        .last_i(last), .valid_i(src_valid), .ready_o(dut_ready),
        .grayscale_o(gray), .last_o(gray_last), .valid_o(dut_valid), .ready_i(sink_ready)
    );

    rgb_to_grayscale_stream #(.PIXEL_W(10), .FRAC_W(7)) dut10 (
        .clk_i(clk), .rst_i(rst), .r_i(r10), .g_i(g10), .b_i(b10), .mode_i(mode10),
        .last_i(last10), .valid_i(valid10), .ready_o(dut10_ready),
        .grayscale_o(gray10), .last_o(gray10_last), .valid_o(dut10_valid), .ready_i(sink10_ready)
    );

    function automatic int ref_gray(int rv, int gv, int bv, int m);
        int cr, cg, cb;
        case (m)
            0:       begin cr = 27; cg = 92;  cb = 9;  end
            1:       begin cr = 38; cg = 75;  cb = 15; end
            2:       begin cr = 43; cg = 42;  cb = 43; end
            default: begin cr = 0;  cg = 128; cb = 0;  end
        endcase
        return (rv * cr + gv * cg + bv * cb + 64) / 128;
    endfunction

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_beat: got %0d, required no beat", gray);
        end else begin
            e = sb.pop_front();
            check_value("gray", {24'd0, gray}, e.gray);
            check_value("last", {31'd0, gray_last}, {31'd0, e.last});
        end
    endtask

    // One cycle: drive at the falling edge, judge both handshakes just before the rising edge.
    task automatic apply_stimulus(input logic v, input logic [7:0] rv, input logic [7:0] gv,
                                  input logic [7:0] bv, input logic [1:0] m, input logic l,
                                  input logic rdy, input int expected, output logic accepted);
        src_valid  = v;
        r          = rv;
        g          = gv;
        b          = bv;
        mode       = m;
        last       = l;
        sink_ready = rdy;
        #1;
        accepted = src_valid && dut_ready;
        if (accepted) sb.push_back('{gray: expected, last: l});
        if (dut_valid && sink_ready) check_output();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        logic a;
        for (int i = 0; i < 20 && (sb.size() != 0 || dut_valid); i++) begin
            apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1, 0, a);
        end
        check_value(name, sb.size(), 0);
    endtask

    task automatic apply_stimulus10(input logic v, input logic [9:0] rv, input logic [9:0] gv,
                                    input logic [9:0] bv, input logic [1:0] m, input logic l,
                                    input int expected);
        exp_t e;
        valid10 = v;
        r10     = rv;
        g10     = gv;
        b10     = bv;
        mode10  = m;
        last10  = l;
        #1;
        if (valid10 && dut10_ready) sb10.push_back('{gray: expected, last: l});
        if (dut10_valid && sink10_ready) begin
            if (sb10.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat10: got %0d, required no beat", gray10);
            end else begin
                e = sb10.pop_front();
                check_value("gray10", {22'd0, gray10}, e.gray);
                check_value("last10", {31'd0, gray10_last}, {31'd0, e.last});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        {r, g, b, mode, last, src_valid} = '0;
        sink_ready = 1'b1;
        {r10, g10, b10, mode10, last10, valid10} = '0;
        sink10_ready = 1'b1;

        vecs[0] = '{8'd100, 8'd50,  8'd200, 2'd0, 1'b0, 71};
        vecs[1] = '{8'd100, 8'd50,  8'd200, 2'd1, 1'b0, 82};
        vecs[2] = '{8'd100, 8'd50,  8'd200, 2'd2, 1'b0, 117};
        vecs[3] = '{8'd100, 8'd50,  8'd200, 2'd3, 1'b1, 50};
        vecs[4] = '{8'd0,   8'd0,   8'd0,   2'd1, 1'b0, 0};
        vecs[5] = '{8'd255, 8'd255, 8'd255, 2'd2, 1'b0, 255};
        vecs[6] = '{8'd2,   8'd0,   8'd0,   2'd2, 1'b0, 1};
        vecs[7] = '{8'd1,   8'd0,   8'd0,   2'd2, 1'b0, 0};
        vecs[8] = '{8'd0,   8'd0,   8'd255, 2'd0, 1'b0, 18};
        vecs[9] = '{8'd255, 8'd0,   8'd0,   2'd1, 1'b1, 76};

        #1;
        check_value("reset_valid", {31'd0, dut_valid}, 0);
        check_value("reset_gray", {24'd0, gray}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("ready_after_reset", {31'd0, dut_ready}, 1);
        @(negedge clk);

        $display("[TB] latency with full-white pixel");
        apply_stimulus(1'b1, 8'd255, 8'd255, 8'd255, 2'd0, 1'b0, 1'b1, 255, acc);
        check_value("lat_cycle1_valid", {31'd0, dut_valid}, 0);
        apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1, 0, acc);
        check_value("lat_cycle2_valid", {31'd0, dut_valid}, 1);
        check_value("lat_cycle2_gray", {24'd0, gray}, 255);
        drain("lat_drain");

        $display("[TB] vector table, back-to-back");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].mode, vecs[i].last,
                           1'b1, vecs[i].expected, acc);
            check_value("table_accept", {31'd0, acc}, 1);
        end
        drain("table_drain");

        $display("[TB] backpressure");
        apply_stimulus(1'b1, 8'd10, 8'd10, 8'd10, 2'd0, 1'b0, 1'b0, 10, acc);
        check_value("bp_accept1", {31'd0, acc}, 1);
        apply_stimulus(1'b1, 8'd20, 8'd20, 8'd20, 2'd0, 1'b0, 1'b0, 20, acc);
        check_value("bp_accept2", {31'd0, acc}, 1);
        apply_stimulus(1'b1, 8'd30, 8'd30, 8'd30, 2'd0, 1'b1, 1'b0, 30, acc);
        check_value("bp_accept3", {31'd0, acc}, 0);
        check_value("bp_ready_low", {31'd0, dut_ready}, 0);
        check_value("bp_hold_valid", {31'd0, dut_valid}, 1);
        check_value("bp_hold_gray", {24'd0, gray}, 10);
        apply_stimulus(1'b1, 8'd30, 8'd30, 8'd30, 2'd0, 1'b1, 1'b0, 30, acc);
        check_value("bp_hold_gray2", {24'd0, gray}, 10);
        check_value("bp_hold_last", {31'd0, gray_last}, 0);
        apply_stimulus(1'b1, 8'd30, 8'd30, 8'd30, 2'd0, 1'b1, 1'b1, 30, acc);
        check_value("bp_accept_release", {31'd0, acc}, 1);
        check_value("bp_next_gray", {24'd0, gray}, 20);
        drain("bp_drain");

        $display("[TB] reset with beats in flight");
        apply_stimulus(1'b1, 8'd200, 8'd200, 8'd200, 2'd0, 1'b0, 1'b0, 200, acc);
        apply_stimulus(1'b1, 8'd201, 8'd201, 8'd201, 2'd0, 1'b1, 1'b0, 201, acc);
        check_value("pre_reset_gray", {24'd0, gray}, 200);
        src_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_value("async_reset_valid", {31'd0, dut_valid}, 0);
        check_value("async_reset_gray", {24'd0, gray}, 0);
        check_value("async_reset_last", {31'd0, gray_last}, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1, 0, acc);
        check_value("post_reset_accept", {31'd0, acc}, 1);
        apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1, 0, acc);
        check_value("post_reset_valid", {31'd0, dut_valid}, 1);
        drain("post_reset_drain");

        $display("[TB] bubbles with random backpressure, 1000 beats");
        for (int n = 0; n < 1000; n++) begin
            rr = 8'($urandom_range(0, 255));
            gg = 8'($urandom_range(0, 255));
            bb = 8'($urandom_range(0, 255));
            mm = 2'($urandom_range(0, 3));
            ll = (n % 17) == 16;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 100) begin
                apply_stimulus(1'b1, rr, gg, bb, mm, ll, 1'($urandom_range(0, 1)),
                               ref_gray(int'(rr), int'(gg), int'(bb), int'(mm)), acc);
                guard++;
            end
            if (!acc) begin
                check_value("bubble_accept_timeout", 0, 1);
                break;
            end
            apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'($urandom_range(0, 1)), 0, acc);
        end
        drain("bubble_drain");

        $display("[TB] 10-bit pixels: corner and random sweep");
        for (int n = 0; n < 204; n++) begin
            if (n < 4) begin
                apply_stimulus10(1'b1, 10'd1023, 10'd1023, 10'd1023, 2'(n), 1'b0, 1023);
            end else begin
                r10 = 10'($urandom_range(0, 1023));
                g10 = 10'($urandom_range(0, 1023));
                b10 = 10'($urandom_range(0, 1023));
                mode10 = 2'($urandom_range(0, 3));
                apply_stimulus10(1'b1, r10, g10, b10, mode10, 1'(n % 5 == 0),
                                 ref_gray(int'(r10), int'(g10), int'(b10), int'(mode10)));
            end
        end
        for (int i = 0; i < 20 && sb10.size() != 0; i++) begin
            apply_stimulus10(1'b0, 10'd0, 10'd0, 10'd0, 2'd0, 1'b0, 0);
        end
        check_value("pix10_drain", sb10.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
